// File: rtl/mem_slot_arbiter_pkg.sv
// mem_arb_pkg: shared types, default parameters and helpers for the memory slot arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int SLICE_DEF = 2;
    localparam int HP_IDX_DEF = 0;
    function automatic logic [7:0] onehot(input int idx);
        onehot = 8'(1) << idx;
    endfunction
endpackage

// File: rtl/mem_slot_arbiter_if.sv
// mem_slot_arbiter_if: request/grant bundle between requesters and the arbiter
interface mem_slot_arbiter_if import mem_arb_pkg::*; #(parameter int N_REQ = N_REQ_DEF);
    localparam int W = $clog2(N_REQ);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [W-1:0] gnt_id;
    logic busy;
    logic preempt;
    modport master(output req, done, input grant, gnt_id, busy, preempt);
    modport slave(input req, done, output grant, gnt_id, busy, preempt);
endinterface

// File: rtl/mem_slot_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, scanning from ptr+1 and skipping masked indices
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic [N-1:0] mask,
    output logic         valid,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;
    // first unmasked request after ptr, wrapping modulo N
    always_comb begin
        valid = 1'b0;
        idx = '0;
        j = '0;
        for (int i = 1; i <= N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!valid && req[j] && !mask[j]) begin
                valid = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: time-sliced memory port arbiter with a preempting high-priority requester
module mem_slot_arbiter import mem_arb_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SLICE = SLICE_DEF,
    parameter int HP_IDX = HP_IDX_DEF
) (
    input logic clk,
    input logic reset,
    mem_slot_arbiter_if.slave bus
);
    localparam int W = $clog2(N_REQ);
    localparam int CW = $clog2(SLICE + 1);
    localparam logic [W-1:0] HP = W'(HP_IDX);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] rr_ptr, rr_n, id_n, pick_idx, win, owner;
    logic [N_REQ-1:0] grant_n, hp_mask;
    logic busy_n, pre_n, pick_v, rel_a, rel_b, rel_c;
    assign hp_mask = N_REQ'(1) << HP_IDX;
    assign owner = bus.gnt_id;
    assign win = bus.req[HP_IDX] ? HP : pick_idx;
    assign rel_a = bus.done[owner] || !bus.req[owner];
    assign rel_b = (owner != HP) && bus.req[HP_IDX];
    assign rel_c = cnt == CW'(SLICE);
    rr_pick #(.N(N_REQ), .W(W)) u_pick (
        .req(bus.req),
        .ptr(rr_ptr),
        .mask(hp_mask),
        .valid(pick_v),
        .idx(pick_idx)
    );
    // next-state: arbitrate when leaving IDLE/TURN, check release conditions while owned
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        rr_n = rr_ptr;
        grant_n = bus.grant;
        id_n = bus.gnt_id;
        busy_n = bus.busy;
        pre_n = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (bus.req[HP_IDX] || pick_v) begin
                    state_n = OWN;
                    grant_n = N_REQ'(onehot(int'(win)));
                    id_n = win;
                    busy_n = 1'b1;
                    cnt_n = CW'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                if (rel_a || rel_b || rel_c) begin
                    state_n = TURN;
                    grant_n = '0;
                    id_n = '0;
                    busy_n = 1'b0;
                    cnt_n = '0;
                    pre_n = !rel_a && rel_b;
                    rr_n = (owner != HP && !pre_n) ? owner : rr_ptr;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state and registered outputs; reset clears everything without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            rr_ptr <= HP;
            bus.grant <= '0;
            bus.gnt_id <= '0;
            bus.busy <= 1'b0;
            bus.preempt <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rr_ptr <= rr_n;
            bus.grant <= grant_n;
            bus.gnt_id <= id_n;
            bus.busy <= busy_n;
            bus.preempt <= pre_n;
        end
    end
endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb_mem_slot_arbiter: table-driven scoreboard bench for the memory slot arbiter
module tb_mem_slot_arbiter;
    typedef struct {
        logic rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] g;
        logic p;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    vec_t tbl[$];
    vec_t sb[$];
    mem_slot_arbiter_if #(.N_REQ(4)) bus();
    mem_slot_arbiter #(.N_REQ(4), .SLICE(2), .HP_IDX(0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = '0;
        for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask
    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] done, input logic [3:0] g, input logic p);
        vec_t v;
        v.rst = rst;
        v.req = req;
        v.done = done;
        v.g = g;
        v.p = p;
        tbl.push_back(v);
    endtask
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst;
        bus.req = v.req;
        bus.done = v.done;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " grant"}, 32'(bus.grant), 32'(e.g));
            chk({tag, " gnt_id"}, 32'(bus.gnt_id), 32'(enc(e.g)));
            chk({tag, " busy"}, 32'(bus.busy), 32'(|e.g));
            chk({tag, " preempt"}, 32'(bus.preempt), 32'(e.p));
            chk({tag, " onehot0"}, 32'($onehot0(bus.grant)), 32'(1));
        end
    endtask
    task automatic hstep(input string tag, input logic [3:0] req, input logic [3:0] done, input logic [3:0] g, input logic p);
        vec_t v;
        v.rst = 1'b0;
        v.req = req;
        v.done = done;
        v.g = g;
        v.p = p;
        step(tag, v);
    endtask
    initial begin
        logic [3:0] pat2 [3];
        logic [3:0] pat3 [11];
        pat2 = '{4'b0010, 4'b0010, 4'b0000};
        pat3 = '{4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010};
        bus.req = '0;
        bus.done = '0;
        add(1, 4'b1111, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 10; i++) add(0, 4'b0010, 4'b0000, pat2[i % 3], 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 11; i++) add(0, 4'b1110, 4'b0000, pat3[i], 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 0);
        add(0, 4'b0011, 4'b0000, 4'b0000, 1);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0);
        add(0, 4'b0011, 4'b0000, 4'b0000, 0);
        add(0, 4'b1110, 4'b0000, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0010, 4'b0100, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0);
        foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);
        hstep("own3", 4'b1000, 4'b0000, 4'b1000, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst grant", 32'(bus.grant), 32'(0));
        chk("async_rst busy", 32'(bus.busy), 32'(0));
        chk("async_rst gnt_id", 32'(bus.gnt_id), 32'(0));
        chk("async_rst preempt", 32'(bus.preempt), 32'(0));
        hstep("post_rst1", 4'b1010, 4'b0000, 4'b0010, 0);
        hstep("post_rst2", 4'b1010, 4'b0000, 4'b0010, 0);
        hstep("post_rst3", 4'b0000, 4'b0000, 4'b0000, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
